// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: host-side transaction sequencer for the SPI-slave/RAM pair.
// Serialises byte write/read requests into two SS_n/MOSI frames, captures MISO.
`timescale 1ns/1ps
module spi_master_ctrl #(
    parameter int IDLE_GAP = 2,
    parameter int RD_GAP   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_op,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic       rsp_op,
    output logic [7:0] rsp_rdata,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SHIFT = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_CAP   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [3:0] SH_LD  = 4'd10;
    localparam logic [3:0] CAP_LD = 4'd7;
    localparam logic [3:0] GAP_LD = 4'(IDLE_GAP - 1);
    localparam logic [3:0] RD_LD  = 4'((RD_GAP > 0) ? RD_GAP - 1 : 0);

    logic [2:0] r_state;
    logic [3:0] r_cnt;
    logic       r_op;
    logic [7:0] r_wdata;
    logic       r_frame2;
    logic [9:0] r_sh;
    logic [6:0] r_cap;
    logic       r_ss_n;
    logic       r_mosi;
    logic       r_rsp_valid;
    logic       r_rsp_op;
    logic [7:0] r_rsp_rdata;
    logic [9:0] w_f2_word;

    // Second frame: cmd 01 carries write data, cmd 11 carries zero payload
    assign w_f2_word = {r_op, 1'b1, (r_op ? 8'h00 : r_wdata)};

    // Sequencer: state, shared down-counter, serial lines and response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op        <= 1'b0;
            r_wdata     <= '0;
            r_frame2    <= 1'b0;
            r_sh        <= '0;
            r_cap       <= '0;
            r_ss_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_op    <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op     <= req_op;
                        r_wdata  <= req_wdata;
                        r_frame2 <= 1'b0;
                        r_sh     <= {req_op, 1'b0, req_addr};
                        r_mosi   <= req_op;
                        r_ss_n   <= 1'b0;
                        r_cnt    <= SH_LD;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != 4'd0) begin
                        r_mosi <= r_sh[9];
                        r_sh   <= {r_sh[8:0], 1'b0};
                        r_cnt  <= r_cnt - 4'd1;
                    end else if (!r_frame2) begin
                        r_ss_n  <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_cnt   <= GAP_LD;
                        r_state <= S_GAP;
                    end else if (r_op) begin
                        r_mosi <= 1'b0;
                        if (RD_GAP == 0) begin
                            r_cnt   <= CAP_LD;
                            r_state <= S_CAP;
                        end else begin
                            r_cnt   <= RD_LD;
                            r_state <= S_WAIT;
                        end
                    end else begin
                        r_ss_n      <= 1'b1;
                        r_mosi      <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_op    <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
                S_GAP: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_frame2 <= 1'b1;
                        r_sh     <= w_f2_word;
                        r_mosi   <= r_op;
                        r_ss_n   <= 1'b0;
                        r_cnt    <= SH_LD;
                        r_state  <= S_SHIFT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_cnt   <= CAP_LD;
                        r_state <= S_CAP;
                    end
                end
                S_CAP: begin
                    r_cap <= {r_cap[5:0], MISO};
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rsp_rdata <= {r_cap, MISO};
                        r_ss_n      <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_op    <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_ss_n      <= 1'b1;
                    r_mosi      <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_op    = r_rsp_op;
    assign rsp_rdata = r_rsp_rdata;
    assign SS_n      = r_ss_n;
    assign MOSI      = r_mosi;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed bench for spi_master_ctrl with a model slave/RAM.
// Instance 0 uses default gaps, instance 1 uses IDLE_GAP=1, RD_GAP=0.
`timescale 1ns/1ps
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_v = 2'b00;
    logic [1:0] rv_v  = 2'b00;
    logic [1:0] mi_v  = 2'b00;
    logic       req_op = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;

    logic       rdy0, rdy1, rsv0, rsv1, rop0, rop1;
    logic       ss0, ss1, mo0, mo1;
    logic [7:0] rd0, rd1;
    logic [1:0] rdy_v, rsv_v, rop_v, ss_v, mo_v;

    assign rdy_v = {rdy1, rdy0};
    assign rsv_v = {rsv1, rsv0};
    assign rop_v = {rop1, rop0};
    assign ss_v  = {ss1, ss0};
    assign mo_v  = {mo1, mo0};

    int checks = 0;
    int errors = 0;

    spi_master_ctrl u_dut0 (
        .clk(clk), .rst_n(rst_v[0]),
        .req_valid(rv_v[0]), .req_ready(rdy0),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsv0), .rsp_op(rop0), .rsp_rdata(rd0),
        .SS_n(ss0), .MOSI(mo0), .MISO(mi_v[0])
    );

    spi_master_ctrl #(.IDLE_GAP(1), .RD_GAP(0)) u_dut1 (
        .clk(clk), .rst_n(rst_v[1]),
        .req_valid(rv_v[1]), .req_ready(rdy1),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsv1), .rsp_op(rop1), .rsp_rdata(rd1),
        .SS_n(ss1), .MOSI(mo1), .MISO(mi_v[1])
    );

    // Model slave/RAM per instance, evaluated mid-cycle
    logic [7:0] smem [2][256];
    int         sn [2] = '{0, 0};
    logic [9:0] sw [2];
    logic [7:0] sa [2];
    logic [7:0] sd [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int n;
            int c0;
            c0 = (i == 0) ? 13 : 11;
            if (ss_v[i] !== 1'b0) begin
                sn[i] = 0;
                mi_v[i] = 1'b0;
            end else begin
                n = sn[i];
                if (n >= 1 && n <= 10) sw[i] = {sw[i][8:0], mo_v[i]};
                if (n == 10) begin
                    case (sw[i][9:8])
                        2'b00, 2'b10: sa[i] = sw[i][7:0];
                        2'b01: smem[i][sa[i]] = sw[i][7:0];
                        default: sd[i] = smem[i][sa[i]];
                    endcase
                end
                if (n >= c0 && n < c0 + 8) mi_v[i] = sd[i][7 - (n - c0)];
                else mi_v[i] = 1'b0;
                sn[i] = n + 1;
            end
        end
    end

    typedef struct {
        int          inst;
        logic        op;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [10:0] f1;
        logic [10:0] f2;
        logic [7:0]  rdata;
        int          lat;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int          g;
        int          lat;
        int          bad;
        logic        ss_t [64];
        logic        mo_t [64];
        logic [10:0] f1, f2, s1, s2;
        logic        gp;
        logic        rop;
        logic [7:0]  rdat;
        g = (v.inst == 0) ? 2 : 1;
        @(negedge clk);
        chk({tag, " ready"}, 32'(rdy_v[v.inst]), 1);
        req_op = v.op;
        req_addr = v.addr;
        req_wdata = v.wdata;
        rv_v[v.inst] = 1'b1;
        @(posedge clk);
        #1;
        rv_v[v.inst] = 1'b0;
        req_op = ~v.op;
        req_addr = ~v.addr;
        req_wdata = ~v.wdata;
        lat = 0;
        rop = 1'bx;
        rdat = 8'hxx;
        for (int k = 1; k < 64; k++) begin
            @(negedge clk);
            ss_t[k] = ss_v[v.inst];
            mo_t[k] = mo_v[v.inst];
            if (rsv_v[v.inst] === 1'b1) begin
                lat = k;
                rop = rop_v[v.inst];
                rdat = (v.inst == 0) ? rd0 : rd1;
                break;
            end
        end
        f1 = '0; s1 = '0; f2 = '0; s2 = '0; gp = 1'b1; bad = 0;
        for (int k = 1; k <= 11; k++) begin
            f1 = {f1[9:0], mo_t[k]};
            s1 = {s1[9:0], ss_t[k]};
        end
        for (int k = 12; k <= 11 + g; k++) gp = gp & ss_t[k];
        for (int k = 12 + g; k <= 22 + g; k++) begin
            f2 = {f2[9:0], mo_t[k]};
            s2 = {s2[9:0], ss_t[k]};
        end
        for (int k = 23 + g; k < lat; k++)
            if (ss_t[k] !== 1'b0 || mo_t[k] !== 1'b0) bad++;
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " frame1 mosi"}, 32'(f1), 32'(v.f1));
        chk({tag, " frame1 ss"}, 32'(s1), 0);
        chk({tag, " gap ss"}, 32'(gp), 1);
        chk({tag, " frame2 mosi"}, 32'(f2), 32'(v.f2));
        chk({tag, " frame2 ss"}, 32'(s2), 0);
        chk({tag, " tail"}, bad, 0);
        chk({tag, " done ss"}, 32'(ss_t[lat]), 1);
        chk({tag, " rsp_op"}, 32'(rop), 32'(v.op));
        chk({tag, " rsp_rdata"}, 32'(rdat), 32'(v.rdata));
        @(negedge clk);
        chk({tag, " pulse end"}, 32'(rsv_v[v.inst]), 0);
        chk({tag, " ready after"}, 32'(rdy_v[v.inst]), 1);
    endtask

    initial begin
        int k1;
        int k2;
        int seen;

        vt[0]  = '{0, 1'b0, 8'h3C, 8'hA5, 11'b0_00_00111100, 11'b0_01_10100101, 8'h00, 25};
        vt[1]  = '{0, 1'b1, 8'h3C, 8'h00, 11'b1_10_00111100, 11'b1_11_00000000, 8'hA5, 35};
        vt[2]  = '{0, 1'b0, 8'h81, 8'h5A, 11'b0_00_10000001, 11'b0_01_01011010, 8'hA5, 25};
        vt[3]  = '{0, 1'b1, 8'h81, 8'hEE, 11'b1_10_10000001, 11'b1_11_00000000, 8'h5A, 35};
        vt[4]  = '{0, 1'b0, 8'h00, 8'hFF, 11'b0_00_00000000, 11'b0_01_11111111, 8'h5A, 25};
        vt[5]  = '{0, 1'b1, 8'h00, 8'h00, 11'b1_10_00000000, 11'b1_11_00000000, 8'hFF, 35};
        vt[6]  = '{0, 1'b0, 8'hFF, 8'h01, 11'b0_00_11111111, 11'b0_01_00000001, 8'hFF, 25};
        vt[7]  = '{0, 1'b1, 8'hFF, 8'h00, 11'b1_10_11111111, 11'b1_11_00000000, 8'h01, 35};
        vt[8]  = '{0, 1'b1, 8'h3C, 8'h00, 11'b1_10_00111100, 11'b1_11_00000000, 8'hA5, 35};
        vt[9]  = '{0, 1'b0, 8'h3C, 8'h00, 11'b0_00_00111100, 11'b0_01_00000000, 8'hA5, 25};
        vt[10] = '{0, 1'b1, 8'h3C, 8'h00, 11'b1_10_00111100, 11'b1_11_00000000, 8'h00, 35};
        vt[11] = '{0, 1'b0, 8'h20, 8'h42, 11'b0_00_00100000, 11'b0_01_01000010, 8'h00, 25};
        vt[12] = '{0, 1'b1, 8'h20, 8'h00, 11'b1_10_00100000, 11'b1_11_00000000, 8'h42, 35};
        vt[13] = '{1, 1'b0, 8'h55, 8'hC3, 11'b0_00_01010101, 11'b0_01_11000011, 8'h00, 24};
        vt[14] = '{1, 1'b1, 8'h55, 8'h00, 11'b1_10_01010101, 11'b1_11_00000000, 8'hC3, 32};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst ss", 32'(ss0), 1);
        chk("rst mosi", 32'(mo0), 0);
        chk("rst ready", 32'(rdy0), 1);
        chk("rst rsp_valid", 32'(rsv0), 0);
        chk("rst rsp_op", 32'(rop0), 0);
        chk("rst rdata", 32'(rd0), 0);
        chk("rst ss i1", 32'(ss1), 1);
        chk("rst ready i1", 32'(rdy1), 1);
        rst_v = 2'b11;
        @(negedge clk);
        chk("post rst ss", 32'(ss0), 1);
        chk("post rst mosi", 32'(mo0), 0);
        chk("post rst ready", 32'(rdy0), 1);

        for (int i = 0; i <= 10; i++) run_vec(vt[i], $sformatf("v%0d", i));

        // Back-to-back: write then read with req_valid held
        @(negedge clk);
        req_op = 1'b0;
        req_addr = 8'h10;
        req_wdata = 8'h77;
        rv_v[0] = 1'b1;
        @(posedge clk);
        #1;
        req_op = 1'b1;
        req_wdata = 8'h11;
        k1 = 0;
        for (int k = 1; k < 64; k++) begin
            @(negedge clk);
            if (rsv0 === 1'b1) begin
                k1 = k;
                break;
            end
        end
        chk("b2b lat1", k1, 25);
        chk("b2b op1", 32'(rop0), 0);
        chk("b2b busy at done", 32'(rdy0), 0);
        @(negedge clk);
        chk("b2b ready", 32'(rdy0), 1);
        @(posedge clk);
        #1;
        rv_v[0] = 1'b0;
        req_addr = 8'hEE;
        chk("b2b accepted", 32'(rdy0), 0);
        k2 = 0;
        for (int k = 1; k < 64; k++) begin
            @(negedge clk);
            if (rsv0 === 1'b1) begin
                k2 = k;
                break;
            end
        end
        chk("b2b lat2", k2, 35);
        chk("b2b op2", 32'(rop0), 1);
        chk("b2b rdata", 32'(rd0), 32'h77);

        // Reset at frame-2 bit 5
        @(negedge clk);
        req_op = 1'b0;
        req_addr = 8'h20;
        req_wdata = 8'h99;
        rv_v[0] = 1'b1;
        @(posedge clk);
        #1;
        rv_v[0] = 1'b0;
        repeat (19) @(negedge clk);
        chk("mid ss low", 32'(ss0), 0);
        rst_v[0] = 1'b0;
        #1;
        chk("abort ss", 32'(ss0), 1);
        chk("abort mosi", 32'(mo0), 0);
        chk("abort ready", 32'(rdy0), 1);
        chk("abort rsp_valid", 32'(rsv0), 0);
        chk("abort rdata", 32'(rd0), 0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsv0 !== 1'b0) seen++;
        end
        rst_v[0] = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (rsv0 !== 1'b0 || ss0 !== 1'b1) seen++;
        end
        chk("abort quiet", seen, 0);

        for (int i = 11; i <= 14; i++) run_vec(vt[i], $sformatf("v%0d", i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
